aoc4_grid_bank: RTL and testbench
=================================

# aoc4_grid_bank

Single-port grid row store and memory responder for the day-4 pruning machines. It serves chunked row reads and writes from `NUM_PORTS` free-machine initiators, with round-robin arbitration, and has a host preload port that takes priority. Each initiator holds a level request until it gets an `ack` pulse, and the initiator's ack handler already relies on this. Each transfer moves exactly one `TX_W`-bit chunk of a `VEC_N`-bit row.

## Interface
- `TX_W`, 64: chunk width in bits.
- `VEC_N`, 192: aligned row width in bits; must be a multiple of `TX_W`.
- `DEPTH`, 256: number of rows.
- `NUM_PORTS`, 2: number of initiator ports (1..8).
- `ROW_AW`, `$clog2(DEPTH)+1`: row address width; carries one spare bit so out-of-range rows can be expressed.
- `COL_AW`, `$clog2(VEC_N)+1`: column address width.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `read_en_in` in `NUM_PORTS`: per-port read request (level).
- `write_en_in` in `NUM_PORTS`: per-port write request (level).
- `row_addr_in` in `NUM_PORTS*ROW_AW`: per-port row address; port p uses slice `[p*ROW_AW +: ROW_AW]`.
- `col_addr_in` in `NUM_PORTS*COL_AW`: per-port column bit offset; must be a multiple of `TX_W`.
- `wdata_in` in `NUM_PORTS*TX_W`: per-port write chunk.
- `ack_out` out `NUM_PORTS`: one-cycle transfer-complete pulse per port.
- `rdata_out` out `NUM_PORTS*TX_W`: per-port read chunk, valid only while that port's ack is high.
- `load_en_in` in 1: host preload request (level).
- `load_row_in` in `ROW_AW`: host preload row.
- `load_col_in` in `COL_AW`: host preload column offset.
- `load_data_in` in `TX_W`: host preload chunk.
- `load_ack_out` out 1: host preload complete pulse.
- `err_out` out 1: sticky flag, set on any out-of-range access.

## Operation
Storage is `DEPTH` rows × `VEC_N/TX_W` chunks. The chunk index is `col_addr/TX_W`. RAM contents are not reset.

FSM states: IDLE, ACCESS, RESP.

IDLE:
- If `load_en_in` is high, latch the host request as a write with source HOST and go to ACCESS.
- Otherwise, if any port has `read_en|write_en` high, grant by round robin and go to ACCESS.
  - Search starts at `last_grant+1` modulo `NUM_PORTS`.
  - Latch the grant: port, op, row, col and wdata. The op is write if `write_en` is high; write wins when both are high.
- With no request, stay in IDLE.

ACCESS:
- Perform a single RAM operation.
- Out of range means row ≥ `DEPTH` or col ≥ `VEC_N`. An out-of-range access performs no write, returns read data of all zeros and sets `err_out`.
- A col that is not aligned to `TX_W` is truncated to `col/TX_W`.
- Go to RESP.

RESP:
- Pulse `ack_out[port]`, or `load_ack_out` for the host.
- Drive `rdata_out[port]` with the read chunk; for writes, drive the written chunk.
- Update `last_grant` to this port; host grants leave it unchanged.
- Go to IDLE.

Other rules:
- A port's `rdata_out` is zero whenever its ack is low.
- Request inputs are sampled only in IDLE. Changes to requests while in ACCESS or RESP are ignored until the next IDLE.

## Timing
- One transfer takes 3 cycles: grant at cycle t, RAM access at t+1, ack at t+2. The earliest next grant is at t+3.
- The initiator may change its address at the ack edge. Because sampling happens in the IDLE cycle after RESP, a stale request is never served twice.
- Read-after-write: a read granted after a write's ack returns the new data.
- Round-robin fairness: a port with a continuously held request is served within `NUM_PORTS` transfers, provided the host port is idle.
- Host starvation of the initiator ports is permitted.
- Reset values: `ack_out=0`, `load_ack_out=0`, `rdata_out=0`, `err_out=0`, state=IDLE, `last_grant=NUM_PORTS-1` (so port 0 is served first).
- Reset mid-operation:
  - The in-flight transfer is dropped and no ack is issued.
  - If reset is high in the ACCESS cycle, no write occurs.
  - The initiator re-requests after reset.
- Simultaneous host and port requests in IDLE: the host wins; the port request stays pending.
- The `err_out` flag clears only on `reset`.

## Test plan
1. Preload then read:
   - Stimulus: host loads row 3, col 64 with `0xA5A5_0000_0000_FFFF`, then port 0 reads row 3, col 64.
   - Required response: `load_ack_out` comes 2 cycles after `load_en`; port 0 ack comes 2 cycles after its grant with `rdata` equal to the loaded value.
2. Write/read-back with both enables:
   - Stimulus: port 1 asserts `write_en` and `read_en` together on row 10, col 128 with `0x1234`, then reads the same location.
   - Required response: the write is performed first and the read returns `0x1234`.
3. Round robin:
   - Stimulus: ports 0 and 1 hold requests continuously from reset.
   - Required response: acks alternate 0,1,0,1, with each ack exactly 3 cycles after the previous one.
4. Out of range:
   - Stimulus: port 0 reads row 256; port 1 writes col 192.
   - Required response: both are acked; the read returns 0; `err_out` rises after the first access and stays high; no RAM location changes.
5. Reset mid-access:
   - Stimulus: assert `reset` in the ACCESS cycle of a port 0 write to row 5.
   - Required response: no ack is issued and row 5 keeps its old value. After reset, port 0 is granted first.
6. Host priority:
   - Stimulus: host and port 0 request in the same IDLE cycle.
   - Required response: `load_ack_out` comes first, then port 0's ack 3 cycles later.

Source files
------------

// File: rtl/aoc4_grid_bank.sv
// aoc4_grid_bank: single-port row store shared by free-machine initiators
// and a host preload port; each transfer moves one chunk in three cycles.
module aoc4_grid_bank #(
  parameter int TX_W      = 64,
  parameter int VEC_N     = 192,
  parameter int DEPTH     = 256,
  parameter int NUM_PORTS = 2,
  parameter int ROW_AW    = $clog2(DEPTH) + 1,
  parameter int COL_AW    = $clog2(VEC_N) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          read_en_in,
  input  logic [NUM_PORTS-1:0]          write_en_in,
  input  logic [NUM_PORTS*ROW_AW-1:0]   row_addr_in,
  input  logic [NUM_PORTS*COL_AW-1:0]   col_addr_in,
  input  logic [NUM_PORTS*TX_W-1:0]     wdata_in,
  output logic [NUM_PORTS-1:0]          ack_out,
  output logic [NUM_PORTS*TX_W-1:0]     rdata_out,
  input  logic                          load_en_in,
  input  logic [ROW_AW-1:0]             load_row_in,
  input  logic [COL_AW-1:0]             load_col_in,
  input  logic [TX_W-1:0]               load_data_in,
  output logic                          load_ack_out,
  output logic                          err_out
);

  localparam int CHUNKS = VEC_N / TX_W;
  localparam int MEM_N  = DEPTH * CHUNKS;
  localparam int MW     = (MEM_N > 1) ? $clog2(MEM_N) : 1;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [TX_W-1:0]      mem [MEM_N];
  logic                 host_q;
  logic                 wr_q;
  logic                 err_q;
  logic [PW-1:0]        port_q;
  logic [PW-1:0]        last_grant;
  logic [PW-1:0]        pick;
  logic                 found;
  logic [ROW_AW-1:0]    row_q;
  logic [COL_AW-1:0]    col_q;
  logic [TX_W-1:0]      wdata_q;
  logic [TX_W-1:0]      resp_q;
  logic [NUM_PORTS-1:0] req;
  logic                 in_range;
  logic [MW-1:0]        addr;

  assign req      = read_en_in | write_en_in;
  assign err_out  = err_q;
  assign in_range = (row_q < ROW_AW'(DEPTH))
                 && (col_q < COL_AW'(VEC_N));
  // Unaligned columns truncate to the chunk that contains them.
  assign addr = MW'(row_q) * MW'(CHUNKS)
              + MW'(col_q / COL_AW'(TX_W));

  // Round-robin search begins one past the last served port.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!found
          && req[PW'((int'(last_grant) + i) % NUM_PORTS)]) begin
        found = 1'b1;
        pick  = PW'((int'(last_grant) + i) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    ack_out      = '0;
    load_ack_out = 1'b0;
    rdata_out    = '0;
    unique case (state)
      IDLE: begin
        if (load_en_in || found) state_nx = ACCESS;
      end
      ACCESS: state_nx = RESP;
      RESP: begin
        state_nx = IDLE;
        if (host_q) begin
          load_ack_out = 1'b1;
        end else begin
          ack_out[port_q] = 1'b1;
          rdata_out[port_q*TX_W +: TX_W] = resp_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= PW'(NUM_PORTS - 1);
      err_q      <= 1'b0;
      host_q     <= 1'b0;
      wr_q       <= 1'b0;
      port_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_en_in) begin
            host_q  <= 1'b1;
            wr_q    <= 1'b1;
            row_q   <= load_row_in;
            col_q   <= load_col_in;
            wdata_q <= load_data_in;
          end else if (found) begin
            host_q  <= 1'b0;
            port_q  <= pick;
            wr_q    <= write_en_in[pick];
            row_q   <= row_addr_in[pick*ROW_AW +: ROW_AW];
            col_q   <= col_addr_in[pick*COL_AW +: COL_AW];
            wdata_q <= wdata_in[pick*TX_W +: TX_W];
          end
        end
        ACCESS: begin
          if (!in_range) err_q <= 1'b1;
          if (wr_q)          resp_q <= wdata_q;
          else if (in_range) resp_q <= mem[addr];
          else               resp_q <= '0;
        end
        RESP: begin
          if (!host_q) last_grant <= port_q;
        end
        default: ;
      endcase
    end
  end

  // Storage is not reset; a reset in ACCESS suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && wr_q && in_range)
      mem[addr] <= wdata_q;
  end

endmodule

// File: tb/tb_aoc4_grid_bank.sv
// Bench for aoc4_grid_bank: directed scenarios plus random traffic,
// scored against a row/chunk memory model through a response queue.
`timescale 1ns/1ps
module tb_aoc4_grid_bank;

  localparam int TX_W   = 64;
  localparam int VEC_N  = 192;
  localparam int DEPTH  = 256;
  localparam int NP     = 2;
  localparam int ROW_AW = 9;
  localparam int COL_AW = 9;
  localparam int CH     = VEC_N / TX_W;
  localparam int HOST   = -1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NP-1:0]        read_en_in  = '0;
  logic [NP-1:0]        write_en_in = '0;
  logic [NP*ROW_AW-1:0] row_addr_in = '0;
  logic [NP*COL_AW-1:0] col_addr_in = '0;
  logic [NP*TX_W-1:0]   wdata_in    = '0;
  logic [NP-1:0]        ack_out;
  logic [NP*TX_W-1:0]   rdata_out;
  logic                 load_en_in   = 1'b0;
  logic [ROW_AW-1:0]    load_row_in  = '0;
  logic [COL_AW-1:0]    load_col_in  = '0;
  logic [TX_W-1:0]      load_data_in = '0;
  logic                 load_ack_out;
  logic                 err_out;

  aoc4_grid_bank dut (
    .clock        (clock),
    .reset        (reset),
    .read_en_in   (read_en_in),
    .write_en_in  (write_en_in),
    .row_addr_in  (row_addr_in),
    .col_addr_in  (col_addr_in),
    .wdata_in     (wdata_in),
    .ack_out      (ack_out),
    .rdata_out    (rdata_out),
    .load_en_in   (load_en_in),
    .load_row_in  (load_row_in),
    .load_col_in  (load_col_in),
    .load_data_in (load_data_in),
    .load_ack_out (load_ack_out),
    .err_out      (err_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          src;
    logic [63:0] data;
    bit          oor;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mem_m [DEPTH][CH];
  bit          err_m = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_oor(input int row, input int col);
    return (row >= DEPTH) || (col >= VEC_N);
  endfunction

  function automatic logic [63:0] model_read(input int row,
                                             input int col);
    if (is_oor(row, col)) return 64'h0;
    return mem_m[row][col / TX_W];
  endfunction

  task automatic model_write(input int row, input int col,
                             input logic [63:0] d);
    if (!is_oor(row, col)) mem_m[row][col / TX_W] = d;
  endtask

  task automatic pop_check(input int src, input logic [63:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: source %0d acked, none pending",
               src);
    end else begin
      e = sbq.pop_front();
      chk("ack_source", 64'(src), 64'(e.src));
      if (src != HOST) chk("rdata", d, e.data);
      if (e.oor) err_m = 1'b1;
      chk("err_out", 64'(err_out), 64'(err_m));
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clock) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        if (ack_out[p])
          pop_check(p, rdata_out[p*TX_W +: TX_W]);
        else
          chk("rdata_zero_without_ack",
              rdata_out[p*TX_W +: TX_W], 64'h0);
      end
      if (load_ack_out) pop_check(HOST, 64'h0);
    end
  end

  task automatic wait_ack(input int p, output int t);
    bit hit;
    hit = 1'b0;
    t = -1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      if (p == HOST) begin
        if (load_ack_out) begin hit = 1'b1; t = cyc; end
      end else begin
        if (ack_out[p]) begin hit = 1'b1; t = cyc; end
      end
    end
    if (!hit) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_port(input int p, input int row, input int col,
                          input logic [63:0] d);
    row_addr_in[p*ROW_AW +: ROW_AW] = ROW_AW'(row);
    col_addr_in[p*COL_AW +: COL_AW] = COL_AW'(col);
    wdata_in[p*TX_W +: TX_W] = d;
  endtask

  task automatic host_load(input int row, input int col,
                           input logic [63:0] d);
    exp_t e;
    int t0, t;
    t0 = cyc;
    load_row_in  = ROW_AW'(row);
    load_col_in  = COL_AW'(col);
    load_data_in = d;
    load_en_in   = 1'b1;
    e = '{src: HOST, data: 64'h0, oor: is_oor(row, col)};
    model_write(row, col, d);
    sbq.push_back(e);
    wait_ack(HOST, t);
    chk("load_ack_latency", 64'(t - t0), 64'd2);
    @(posedge clock); #1;
    load_en_in = 1'b0;
  endtask

  task automatic port_req(input int p, input bit wr, input bit rd,
                          input int row, input int col,
                          input logic [63:0] d);
    exp_t e;
    int t0, t;
    t0 = cyc;
    set_port(p, row, col, d);
    write_en_in[p] = wr;
    read_en_in[p]  = rd;
    e.src = p;
    e.oor = is_oor(row, col);
    if (wr) begin
      e.data = d;
      model_write(row, col, d);
    end else begin
      e.data = model_read(row, col);
    end
    sbq.push_back(e);
    wait_ack(p, t);
    chk("port_ack_latency", 64'(t - t0), 64'd2);
    @(posedge clock); #1;
    write_en_in[p] = 1'b0;
    read_en_in[p]  = 1'b0;
  endtask

  task automatic rr_run(input int n, output int first_t);
    int got, prev;
    got = 0;
    prev = 0;
    first_t = -1;
    for (int i = 0; i < 10 * n && got < n; i++) begin
      @(negedge clock);
      if (|ack_out) begin
        if (got == 0) first_t = cyc;
        else chk("rr_ack_spacing", 64'(cyc - prev), 64'd3);
        prev = cyc;
        got++;
      end
    end
    chk("rr_ack_count", 64'(got), 64'(n));
  endtask

  task automatic push_read(input int p, input int row, input int col);
    exp_t e;
    e = '{src: p, data: model_read(row, col), oor: 1'b0};
    sbq.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, tf, n;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ack", 64'(ack_out), 64'd0);
    chk("reset_load_ack", 64'(load_ack_out), 64'd0);
    chk("reset_rdata", rdata_out[63:0] | rdata_out[127:64], 64'd0);
    chk("reset_err", 64'(err_out), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Known contents for rows 0..15.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < CH; c++)
        host_load(r, c * TX_W, {$urandom, $urandom});

    // 1: preload then read.
    host_load(3, 64, 64'hA5A5_0000_0000_FFFF);
    port_req(0, 1'b0, 1'b1, 3, 64, 64'h0);

    // 2: write wins when both enables are high.
    port_req(1, 1'b1, 1'b1, 10, 128, 64'h1234);
    port_req(1, 1'b0, 1'b1, 10, 128, 64'h0);

    // 3: round robin with both ports held from reset.
    reset = 1'b1;
    sbq.delete();
    err_m = 1'b0;
    set_port(0, 3, 64, 64'h0);
    set_port(1, 10, 128, 64'h0);
    read_en_in = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_read(0, 3, 64);
      else            push_read(1, 10, 128);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    t0 = cyc;
    rr_run(4, tf);
    chk("rr_first_latency", 64'(tf - t0), 64'd2);
    @(posedge clock); #1;
    read_en_in = '0;

    // 4: out-of-range read and write.
    chk("err_before_oor", 64'(err_out), 64'd0);
    port_req(0, 1'b0, 1'b1, 256, 0, 64'h0);
    port_req(1, 1'b1, 1'b0, 3, 192, 64'hDEAD_BEEF_0BAD_F00D);
    port_req(1, 1'b0, 1'b1, 4, 0, 64'h0);
    port_req(0, 1'b0, 1'b1, 3, 64, 64'h0);

    // 5: reset during the ACCESS cycle of a write.
    set_port(0, 5, 0, 64'hFFFF_EEEE_DDDD_CCCC);
    write_en_in[0] = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    write_en_in[0] = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    sbq.delete();
    err_m = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (|ack_out || load_ack_out) n++;
    end
    chk("no_ack_after_reset", 64'(n), 64'd0);
    chk("err_cleared_by_reset", 64'(err_out), 64'd0);
    @(posedge clock); #1;
    set_port(0, 5, 0, 64'h0);
    set_port(1, 10, 128, 64'h0);
    read_en_in = 2'b11;
    push_read(0, 5, 0);
    push_read(1, 10, 128);
    t0 = cyc;
    rr_run(2, tf);
    chk("post_reset_latency", 64'(tf - t0), 64'd2);
    @(posedge clock); #1;
    read_en_in = '0;

    // 6: host and port 0 request together.
    t0 = cyc;
    load_row_in  = ROW_AW'(7);
    load_col_in  = COL_AW'(0);
    load_data_in = 64'h0123_4567_89AB_CDEF;
    load_en_in   = 1'b1;
    set_port(0, 7, 64, 64'h5555_AAAA_5555_AAAA);
    write_en_in[0] = 1'b1;
    sbq.push_back('{src: HOST, data: 64'h0, oor: 1'b0});
    model_write(7, 0, 64'h0123_4567_89AB_CDEF);
    sbq.push_back('{src: 0, data: 64'h5555_AAAA_5555_AAAA,
                    oor: 1'b0});
    model_write(7, 64, 64'h5555_AAAA_5555_AAAA);
    wait_ack(HOST, t1);
    chk("host_first_latency", 64'(t1 - t0), 64'd2);
    @(posedge clock); #1;
    load_en_in = 1'b0;
    wait_ack(0, t2);
    chk("port_after_host", 64'(t2 - t1), 64'd3);
    @(posedge clock); #1;
    write_en_in[0] = 1'b0;
    port_req(0, 1'b0, 1'b1, 7, 0, 64'h0);
    port_req(1, 1'b0, 1'b1, 7, 64, 64'h0);

    // Random sequential traffic.
    for (int k = 0; k < 150; k++) begin
      int row, col, p, op;
      logic [63:0] d;
      row = $urandom_range(0, 15);
      col = $urandom_range(0, CH - 1) * TX_W;
      if ($urandom_range(0, 5) == 0) col += $urandom_range(1, TX_W - 1);
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 1) == 1) row = $urandom_range(DEPTH, 511);
        else col = $urandom_range(VEC_N, 511);
      end
      d = {$urandom, $urandom};
      p = $urandom_range(0, NP - 1);
      op = $urandom_range(0, 3);
      case (op)
        0:       host_load(row, col, d);
        1:       port_req(p, 1'b1, 1'b0, row, col, d);
        2:       port_req(p, 1'b0, 1'b1, row, col, d);
        default: port_req(p, 1'b1, 1'b1, row, col, d);
      endcase
    end

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
